// File: rtl/multdiv_unit.sv
// Iterative signed multiply / divide unit for the execute stage.
// Shift-add multiply or restoring divide on magnitudes, one iteration per clock, sign fixed at completion.
module multdiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             ctrl_mult,
    input  logic             ctrl_div,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic             busy,
    output logic             data_ready,
    output logic [WIDTH-1:0] result,
    output logic             exception
);

    localparam logic [1:0]         ST_IDLE  = 2'd0;
    localparam logic [1:0]         ST_RUN   = 2'd1;
    localparam logic [1:0]         ST_DONE  = 2'd2;
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0]   CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0]   ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [2*WIDTH-1:0] ONE_2W   = {{(2*WIDTH-1){1'b0}}, 1'b1};

    function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] v);
        abs_val = v[WIDTH-1] ? (~v + ONE_W) : v;
    endfunction

    logic [1:0]         state_r;
    logic [CNT_W-1:0]   count_r;
    logic               sign_r;
    logic               op_div_r;
    logic [WIDTH-1:0]   mag_a_r;
    logic [WIDTH-1:0]   mag_b_r;
    logic [2*WIDTH-1:0] acc_r;
    logic               busy_r;
    logic               ready_r;
    logic [WIDTH-1:0]   result_r;
    logic               exception_r;

    logic               start_s;
    logic               start_div_s;
    logic               div_zero_s;
    logic [WIDTH:0]     madd_s;
    logic [2*WIDTH-1:0] mult_next_s;
    logic [WIDTH:0]     rem_shift_s;
    logic [WIDTH:0]     rem_diff_s;
    logic [2*WIDTH-1:0] div_next_s;
    logic [2*WIDTH-1:0] acc_next_s;
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0]   quo_s;
    logic [WIDTH-1:0]   fin_result_s;
    logic               fin_exc_s;

    // Start decode and one iteration of the datapath, including the final sign fix-up.
    always_comb begin
        start_s     = ctrl_mult | ctrl_div;
        start_div_s = ctrl_div & ~ctrl_mult;
        div_zero_s  = start_div_s & (operand_b == {WIDTH{1'b0}});

        // Multiply: acc high half accumulates, low half collects product bits shifted in from above.
        madd_s      = {1'b0, acc_r[2*WIDTH-1:WIDTH]} + (mag_b_r[0] ? {1'b0, mag_a_r} : {(WIDTH+1){1'b0}});
        mult_next_s = {madd_s, acc_r[WIDTH-1:1]};

        // Divide: acc = {remainder, quotient}; dividend bits enter MSB-first from mag_a_r.
        rem_shift_s = {acc_r[2*WIDTH-1:WIDTH], mag_a_r[WIDTH-1]};
        rem_diff_s  = rem_shift_s - {1'b0, mag_b_r};
        if (!rem_diff_s[WIDTH]) begin
            div_next_s = {rem_diff_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b1};
        end else begin
            div_next_s = {rem_shift_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b0};
        end

        acc_next_s = op_div_r ? div_next_s : mult_next_s;
        prod_s     = sign_r ? (~acc_next_s + ONE_2W) : acc_next_s;
        quo_s      = sign_r ? (~acc_next_s[WIDTH-1:0] + ONE_W) : acc_next_s[WIDTH-1:0];

        if (op_div_r) begin
            fin_result_s = quo_s;
            fin_exc_s    = ~sign_r & quo_s[WIDTH-1];
        end else begin
            fin_result_s = prod_s[WIDTH-1:0];
            fin_exc_s    = (prod_s[2*WIDTH-1:WIDTH] != {WIDTH{prod_s[WIDTH-1]}});
        end
    end

    // Control FSM, operand/accumulator registers and registered outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= ST_IDLE;
            count_r     <= {CNT_W{1'b0}};
            sign_r      <= 1'b0;
            op_div_r    <= 1'b0;
            mag_a_r     <= {WIDTH{1'b0}};
            mag_b_r     <= {WIDTH{1'b0}};
            acc_r       <= {(2*WIDTH){1'b0}};
            busy_r      <= 1'b0;
            ready_r     <= 1'b0;
            result_r    <= {WIDTH{1'b0}};
            exception_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start_s) begin
                        sign_r   <= operand_a[WIDTH-1] ^ operand_b[WIDTH-1];
                        op_div_r <= start_div_s;
                        mag_a_r  <= abs_val(operand_a);
                        mag_b_r  <= abs_val(operand_b);
                        acc_r    <= {(2*WIDTH){1'b0}};
                        count_r  <= {CNT_W{1'b0}};
                        if (div_zero_s) begin
                            state_r     <= ST_DONE;
                            ready_r     <= 1'b1;
                            result_r    <= {WIDTH{1'b0}};
                            exception_r <= 1'b1;
                        end else begin
                            state_r     <= ST_RUN;
                            busy_r      <= 1'b1;
                            exception_r <= 1'b0;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    acc_r   <= acc_next_s;
                    mag_a_r <= op_div_r ? {mag_a_r[WIDTH-2:0], 1'b0} : mag_a_r;
                    mag_b_r <= op_div_r ? mag_b_r : {1'b0, mag_b_r[WIDTH-1:1]};
                    if (count_r == CNT_LAST) begin
                        count_r     <= {CNT_W{1'b0}};
                        state_r     <= ST_DONE;
                        busy_r      <= 1'b0;
                        ready_r     <= 1'b1;
                        result_r    <= fin_result_s;
                        exception_r <= fin_exc_s;
                    end else begin
                        count_r <= count_r + CNT_ONE;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                    ready_r <= 1'b0;
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                    ready_r <= 1'b0;
                end
            endcase
        end
    end

    assign busy       = busy_r;
    assign data_ready = ready_r;
    assign result     = result_r;
    assign exception  = exception_r;

endmodule

// File: tb/tb_multdiv_unit.sv
// Directed, table-driven bench for multdiv_unit, with hand-written reset-abort and ignored-start sequences.
module tb_multdiv_unit;

    logic        clock;
    logic        reset_n;
    logic        ctrl_mult;
    logic        ctrl_div;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic        busy;
    logic        data_ready;
    logic [31:0] result;
    logic        exception;

    int n_cmp;
    int n_fail;

    multdiv_unit #(.WIDTH(32), .CNT_W(5)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .ctrl_mult  (ctrl_mult),
        .ctrl_div   (ctrl_div),
        .operand_a  (operand_a),
        .operand_b  (operand_b),
        .busy       (busy),
        .data_ready (data_ready),
        .result     (result),
        .exception  (exception)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        string       name;
        logic        m;
        logic        d;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        exc;
        int          lat;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Called one #1 after a posedge; start is sampled at the next edge (E0).
    task automatic run_op(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b,
                          input int inj,
                          output logic [31:0] res, output logic exc, output int lat,
                          output int busy_cnt, output int overlap, output logic exc_at1,
                          output logic [31:0] idle_res);
        logic done;
        ctrl_mult = m; ctrl_div = d; operand_a = a; operand_b = b;
        @(posedge clock); #1;
        ctrl_mult = 1'b0; ctrl_div = 1'b0;
        operand_a = 32'hDEAD_BEEF; operand_b = 32'h0000_0000;
        res = 32'hXXXX_XXXX; exc = 1'bx; lat = 0; busy_cnt = 0; overlap = 0;
        exc_at1 = exception;
        done = 1'b0;
        for (int c = 1; c <= 40 && !done; c++) begin
            if (busy && data_ready) overlap++;
            if (busy) busy_cnt++;
            if (data_ready) begin
                lat = c; res = result; exc = exception; done = 1'b1;
            end else begin
                if (c == inj) begin
                    ctrl_div = 1'b1; operand_a = 32'd9; operand_b = 32'd3;
                end
                @(posedge clock); #1;
                ctrl_div = 1'b0;
            end
        end
        @(posedge clock); #1;
        if (busy || data_ready) overlap++;
        idle_res = result;
    endtask

    logic [31:0] r_res, r_idle;
    logic        r_exc, r_exc1;
    int          r_lat, r_busy, r_ovl, ready_seen;

    initial begin
        n_cmp = 0; n_fail = 0;
        vecs[0]  = '{"mul_7_m6",      1'b1, 1'b0, 32'd7,          32'hFFFF_FFFA, 32'hFFFF_FFD6, 1'b0, 33};
        vecs[1]  = '{"mul_ovf_2p32",  1'b1, 1'b0, 32'h0001_0000,  32'h0001_0000, 32'h0000_0000, 1'b1, 33};
        vecs[2]  = '{"mul_min_m1",    1'b1, 1'b0, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 33};
        vecs[3]  = '{"div_m7_2",      1'b0, 1'b1, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 1'b0, 33};
        vecs[4]  = '{"div_100_0",     1'b0, 1'b1, 32'd100,        32'd0,         32'h0000_0000, 1'b1, 1};
        vecs[5]  = '{"both_5_3",      1'b1, 1'b1, 32'd5,          32'd3,         32'd15,        1'b0, 33};
        vecs[6]  = '{"div_min_m1",    1'b0, 1'b1, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 33};
        vecs[7]  = '{"div_7_m2",      1'b0, 1'b1, 32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0, 33};
        vecs[8]  = '{"mul_m5_m5",     1'b1, 1'b0, 32'hFFFF_FFFB,  32'hFFFF_FFFB, 32'd25,        1'b0, 33};
        vecs[9]  = '{"div_m100_7",    1'b0, 1'b1, 32'hFFFF_FF9C,  32'd7,         32'hFFFF_FFF2, 1'b0, 33};
        vecs[10] = '{"mul_m1_m1",     1'b1, 1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'd1,         1'b0, 33};
        vecs[11] = '{"div_0_5",       1'b0, 1'b1, 32'd0,          32'd5,         32'd0,         1'b0, 33};

        reset_n = 1'b0; ctrl_mult = 1'b0; ctrl_div = 1'b0;
        operand_a = 32'd0; operand_b = 32'd0;
        #1;
        chk("rst_busy",  {31'd0, busy},       32'd0);
        chk("rst_ready", {31'd0, data_ready}, 32'd0);
        chk("rst_result", result,             32'd0);
        chk("rst_exc",   {31'd0, exception},  32'd0);
        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;
        @(posedge clock); #1;

        // Back-to-back table: each op starts in the IDLE cycle right after the previous DONE.
        for (int i = 0; i < 12; i++) begin
            run_op(vecs[i].m, vecs[i].d, vecs[i].a, vecs[i].b, 0,
                   r_res, r_exc, r_lat, r_busy, r_ovl, r_exc1, r_idle);
            chk({vecs[i].name, "_result"},  r_res,             vecs[i].res);
            chk({vecs[i].name, "_exc"},     {31'd0, r_exc},    {31'd0, vecs[i].exc});
            chk({vecs[i].name, "_latency"}, r_lat,             vecs[i].lat);
            chk({vecs[i].name, "_busycnt"}, r_busy,            (vecs[i].lat == 1) ? 32'd0 : 32'd32);
            chk({vecs[i].name, "_overlap"}, r_ovl,             32'd0);
            chk({vecs[i].name, "_hold"},    r_idle,            vecs[i].res);
            if (vecs[i].lat != 1)
                chk({vecs[i].name, "_exc_clr"}, {31'd0, r_exc1}, 32'd0);
        end

        // Divide pulse injected in cycle 5 of RUN must be ignored.
        run_op(1'b1, 1'b1, 32'd5, 32'd3, 5, r_res, r_exc, r_lat, r_busy, r_ovl, r_exc1, r_idle);
        chk("inject_result",  r_res,          32'd15);
        chk("inject_exc",     {31'd0, r_exc}, 32'd0);
        chk("inject_latency", r_lat,          32'd33);
        chk("inject_overlap", r_ovl,          32'd0);

        // Reset in cycle 10 of a multiply aborts it with no data_ready.
        ctrl_mult = 1'b1; operand_a = 32'd7; operand_b = 32'd6;
        @(posedge clock); #1;
        ctrl_mult = 1'b0;
        repeat (9) begin @(posedge clock); #1; end
        chk("abort_busy_before", {31'd0, busy}, 32'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("abort_busy",   {31'd0, busy},       32'd0);
        chk("abort_ready",  {31'd0, data_ready}, 32'd0);
        chk("abort_result", result,              32'd0);
        chk("abort_exc",    {31'd0, exception},  32'd0);
        @(posedge clock); #1 reset_n = 1'b1;
        ready_seen = 0;
        repeat (40) begin
            @(posedge clock); #1;
            if (data_ready || busy) ready_seen++;
        end
        chk("abort_no_ready", ready_seen, 32'd0);
        run_op(1'b1, 1'b0, 32'd3, 32'd4, 0, r_res, r_exc, r_lat, r_busy, r_ovl, r_exc1, r_idle);
        chk("after_abort_result",  r_res,          32'd12);
        chk("after_abort_exc",     {31'd0, r_exc}, 32'd0);
        chk("after_abort_latency", r_lat,          32'd33);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/multdiv_unit.md
Name: multdiv_unit

Overview:
- Iterative signed 32-bit multiply/divide unit in the execute stage of the 5-stage pipeline.
- Accepts a one-cycle start pulse from the DX stage and runs a 32-iteration shift-add multiply or restoring divide.
- Drives `busy`, which the hazard/stall logic consumes as its multdiv stall request (`mult_operation`). It freezes PC/FD and bubbles DX until the result is ready.
- Reports completion with a one-cycle `data_ready` pulse plus `result` and `exception` for the XM stage.

Parameters:
- WIDTH, 32, operand/result width in bits.
- CNT_W, 5, iteration counter width; log2(WIDTH).

Ports:
- clock, input, 1, sole clock; all state updates on the rising edge.
- reset_n, input, 1, asynchronous active-low reset.
- ctrl_mult, input, 1, one-cycle start pulse for a multiply.
- ctrl_div, input, 1, one-cycle start pulse for a divide.
- operand_a, input, WIDTH, multiplicand or dividend; sampled only on a start edge.
- operand_b, input, WIDTH, multiplier or divisor; sampled only on a start edge.
- busy, output, 1, high while iterating; this is the stall request.
- data_ready, output, 1, one-cycle pulse when `result` and `exception` are valid.
- result, output, WIDTH, signed product (low WIDTH bits) or quotient.
- exception, output, 1, overflow or divide-by-zero flag; valid with `data_ready`.

Behaviour:
- States:
  - IDLE: waits for a start pulse.
  - RUN: iterates; counter counts 0..WIDTH-1.
  - DONE: lasts exactly 1 cycle.
- Reset (reset_n=0, asynchronous):
  - state=IDLE, counter=0.
  - busy=0, data_ready=0, result=0, exception=0.
  - All internal operand, accumulator and remainder registers are cleared.
- Reset mid-RUN aborts the operation. No `data_ready` is produced for the aborted operation.
- IDLE→RUN on an edge with ctrl_mult=1 or ctrl_div=1:
  - Latch the magnitudes of `operand_a` and `operand_b`.
  - Latch result sign = sign(a) XOR sign(b), and the operation type.
  - Clear the accumulator and counter.
- ctrl_mult and ctrl_div both high in the same cycle: multiply wins; the divide is dropped.
- Start pulses seen in RUN or DONE are ignored. The stall unit guarantees none occur; the bench checks they are ignored.
- RUN:
  - One iteration per cycle, 32 cycles.
  - Multiply: shift-add on magnitudes; a 64-bit product is held internally.
  - Divide: restoring algorithm on magnitudes; 32-bit quotient and 32-bit remainder.
  - RUN→DONE on the edge where counter=WIDTH-1.
- DONE:
  - data_ready=1 and busy=0.
  - `result` and `exception` are registered and presented in this cycle.
  - DONE→IDLE on the next edge.
- Outputs in IDLE:
  - `result` and `exception` hold their last values until the next start edge, which clears `exception`.
- Timing: start sampled at edge E0 → busy=1 during the 32 cycles after E0 → data_ready=1 in the 33rd cycle after E0 → busy=0 again from that cycle.
- busy is registered: it is 0 in the cycle the start pulse is applied. DX-stage logic must stall on the start cycle itself.
- Sign fix-up: the two's-complement negation is applied at the RUN→DONE edge.
- Multiply exception = 1 when the signed 64-bit product ≠ sign-extension of its low 32 bits; `result` is still the low 32 bits.
- Divide by zero: detected at the start edge. The unit skips RUN and goes IDLE→DONE, so data_ready is asserted the cycle after start, with result=0 and exception=1.
- Divide 0x80000000 / 0xFFFFFFFF: exception=1, result=0x80000000.
- Quotient truncates toward zero. The remainder is not output.
- busy and data_ready are never high in the same cycle.

Test Plan:
- Reset mid-operation: start mult 7×6, assert reset_n=0 at cycle 10 → busy, data_ready, result and exception all drop to 0 immediately (asynchronously); no data_ready follows. A new mult 3×4 started afterwards → result=12.
- ctrl_mult with a=7, b=-6 → busy high for exactly 32 cycles; data_ready in cycle 33 with result=0xFFFFFFD6 (-42), exception=0.
- ctrl_mult with a=0x00010000, b=0x00010000 → result=0x00000000, exception=1 (overflow); also 0x80000000×0xFFFFFFFF → exception=1.
- ctrl_div with a=-7, b=2 → result=0xFFFFFFFD (-3), exception=0, latency 33 cycles. Then a=100, b=0 → data_ready the cycle after start, result=0, exception=1, busy never asserted.
- ctrl_mult and ctrl_div high together with a=5, b=3 → result=15. A ctrl_div pulse with a=9, b=3 injected at cycle 5 of RUN is ignored; result stays 15.
- Back-to-back: a new start in the cycle after data_ready (IDLE) → accepted. busy rises on the next cycle, exception from the previous op is cleared, and busy/data_ready never overlap.
